// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the burst-aware round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCK} arb_state_t;

  localparam int MAX_REQ   = 16;
  localparam int MAX_SRC_W = $clog2(MAX_REQ);

  // Advance a round-robin index, wrapping explicitly at n-1 so non-power-of-two counts work.
  function automatic logic [MAX_SRC_W-1:0] rr_next(input logic [MAX_SRC_W-1:0] idx, input int n);
    if (idx == MAX_SRC_W'(n - 1)) return '0;
    return idx + MAX_SRC_W'(1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_priority_picker
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic             any,
  output logic [SRC_W-1:0] idx
);

  logic [SRC_W:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (SRC_W + 1)'(k);
      if (pos >= (SRC_W + 1)'(N_REQ)) pos = pos - (SRC_W + 1)'(N_REQ);
      if (req[pos[SRC_W-1:0]]) begin
        any = 1'b1;
        idx = pos[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_burst_arbiter.sv
// Round-robin arbiter sharing one registered W-bit datapath; a grant is held until the burst's last beat.
module mux_burst_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [N_REQ-1:0]   in_last,
  input  logic [N_REQ*W-1:0] in_data,
  output logic [N_REQ-1:0]   in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic               out_last,
  output logic [SRC_W-1:0]   out_src,
  input  logic               out_ready
);

  arb_state_t       state;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] gnt;
  logic             pick_any;
  logic [SRC_W-1:0] pick_idx;
  logic [SRC_W-1:0] cand;
  logic             room;
  logic             xfer;
  logic [W-1:0]     cand_data;
  logic [W-1:0]     lane [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = in_data[i*W +: W];
  end

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req (in_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Ready is gated by rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    cand      = (state == ARB_LOCK) ? gnt : pick_idx;
    room      = !out_valid || out_ready;
    in_ready  = '0;
    if (rst_n && room && (state == ARB_LOCK || pick_any)) in_ready[cand] = 1'b1;
    xfer      = in_valid[cand] && in_ready[cand];
    cand_data = lane[cand];
  end

  // Output register stage and arbitration FSM share one clocked block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        out_last  <= in_last[cand];
        out_src   <= cand;
      end else if (out_ready && out_valid) begin
        out_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (xfer) begin
            if (in_last[cand]) begin
              ptr <= SRC_W'(rr_next(MAX_SRC_W'(cand), N_REQ));
            end else begin
              state <= ARB_LOCK;
              gnt   <= cand;
            end
          end
        end
        ARB_LOCK: begin
          if (xfer && in_last[cand]) begin
            state <= ARB_IDLE;
            ptr   <= SRC_W'(rr_next(MAX_SRC_W'(gnt), N_REQ));
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_burst_arbiter.sv
// Self-checking bench for mux_burst_arbiter: directed scenarios plus a randomized run against a cycle model.
module tb_mux_burst_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_last, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;

  logic [2:0]     v3, l3, r3;
  logic [23:0]    d3;
  logic           ov3, ol3, ordy3;
  logic [7:0]     od3;
  logic [1:0]     os3;

  int checks = 0;
  int errors = 0;

  mux_burst_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  mux_burst_arbiter #(.N_REQ(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_last(l3), .in_data(d3),
    .in_ready(r3), .out_valid(ov3), .out_data(od3), .out_last(ol3),
    .out_src(os3), .out_ready(ordy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    v3 = '0; l3 = '0; d3 = '0; ordy3 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(32'h40 + i);
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    end
    rst_n = 1'b1; #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready: got %b expected 0001", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL reset_first_src: got v=%b src=%0d expected v=1 src=0", out_valid, out_src); end
    checks++; if (out_data !== 8'h40) begin errors++; $display("FAIL reset_first_data: got %h expected 40", out_data); end
    in_valid = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(32'h40 + i);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_src !== 2'(k % 4) || out_data !== 8'(32'h40 + k % 4))
        begin errors++; $display("FAIL fairness_%0d: got src=%0d data=%h expected src=%0d", k, out_src, out_data, k % 4); end
    end
    in_valid = '0;
  endtask

  task automatic test_burst_lock();
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0010; in_data[8 +: 8] = 8'h51;
    @(negedge clk);
    checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL burst_pre_src: got %0d expected 1", out_src); end
    in_valid = 4'b0110;
    for (int b = 0; b < 3; b++) begin
      in_data[16 +: 8] = 8'(32'hA0 + b); in_last[2] = (b == 2); #1;
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL burst_ready_%0d: got %b expected 0100", b, in_ready); end
      @(negedge clk);
      checks++;
      if (out_src !== 2'd2 || out_data !== 8'(32'hA0 + b) || out_last !== (b == 2))
        begin errors++; $display("FAIL burst_beat_%0d: got src=%0d data=%h last=%b expected src=2 data=%h", b, out_src, out_data, out_last, 8'(32'hA0 + b)); end
    end
    in_valid = 4'b0010; #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL burst_after_ready: got %b expected 0010", in_ready); end
    @(negedge clk);
    checks++; if (out_src !== 2'd1 || out_data !== 8'h51) begin errors++; $display("FAIL burst_after_src: got src=%0d data=%h expected src=1 data=51", out_src, out_data); end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [7:0] nxt;
    do_reset();
    out_ready = 1'b0; in_valid = 4'b0010; in_last = 4'b0010; in_data[8 +: 8] = 8'h11; #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready: got %b expected 0010", in_ready); end
    @(negedge clk);
    in_data[8 +: 8] = 8'h12;
    repeat (4) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0000", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 2'd1)
        begin errors++; $display("FAIL bp_stall_hold: got v=%b data=%h src=%0d expected v=1 data=11 src=1", out_valid, out_data, out_src); end
      @(negedge clk);
    end
    out_ready = 1'b1; nxt = 8'h12;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_stream_ready_%0d: got %b expected 0010", k, in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== nxt) begin errors++; $display("FAIL bp_stream_%0d: got v=%b data=%h expected v=1 data=%h", k, out_valid, out_data, nxt); end
      nxt = nxt + 8'd1; in_data[8 +: 8] = nxt;
    end
    in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    in_valid = 4'b1000; in_last = 4'b0000; in_data[24 +: 8] = 8'h30;
    @(negedge clk);
    in_data[24 +: 8] = 8'h31; in_valid = 4'b1001; in_data[0 +: 8] = 8'h77; in_last[0] = 1'b1; #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL midrst_lock_ready: got %b expected 1000", in_ready); end
    @(negedge clk);
    checks++; if (out_src !== 2'd3 || out_data !== 8'h31) begin errors++; $display("FAIL midrst_beat2: got src=%0d data=%h expected src=3 data=31", out_src, out_data); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0000", in_ready); end
    #1 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_idle_ready: got %b expected 0001", in_ready); end
    @(negedge clk);
    checks++; if (out_src !== 2'd0 || out_data !== 8'h77) begin errors++; $display("FAIL midrst_winner: got src=%0d data=%h expected src=0 data=77", out_src, out_data); end
    in_valid = '0;
  endtask

  task automatic test_wrap3();
    do_reset();
    v3 = 3'b010; l3 = 3'b111; d3 = {8'hC2, 8'hC1, 8'hC0};
    @(negedge clk);
    checks++; if (os3 !== 2'd1) begin errors++; $display("FAIL wrap_pre_src: got %0d expected 1", os3); end
    v3 = 3'b101; #1;
    checks++; if (r3 !== 3'b100) begin errors++; $display("FAIL wrap_ready2: got %b expected 100", r3); end
    @(negedge clk);
    checks++; if (os3 !== 2'd2 || od3 !== 8'hC2) begin errors++; $display("FAIL wrap_src2: got src=%0d data=%h expected src=2 data=c2", os3, od3); end
    #1;
    checks++; if (r3 !== 3'b001) begin errors++; $display("FAIL wrap_ready0: got %b expected 001", r3); end
    @(negedge clk);
    checks++; if (os3 !== 2'd0 || od3 !== 8'hC0) begin errors++; $display("FAIL wrap_src0: got src=%0d data=%h expected src=0 data=c0", os3, od3); end
    v3 = '0;
  endtask

  // Cycle model: owner < 0 means no burst in progress; priority search uses modulo arithmetic.
  task automatic test_random();
    int         owner, mptr, cand, hit;
    bit         mov, mlast, xfer, room;
    logic [7:0] mdata;
    int         msrc;
    logic [N-1:0] exp_rdy;
    do_reset();
    owner = -1; mptr = 0; mov = 0; mlast = 0; mdata = '0; msrc = 0;
    for (int k = 0; k < 400; k++) begin
      checks++; if (out_valid !== mov) begin errors++; $display("FAIL rand_valid_%0d: got %b expected %b", k, out_valid, mov); end
      if (mov) begin
        checks++;
        if (out_data !== mdata || out_src !== 2'(msrc) || out_last !== mlast)
          begin errors++; $display("FAIL rand_beat_%0d: got data=%h src=%0d last=%b expected data=%h src=%0d last=%b", k, out_data, out_src, out_last, mdata, msrc, mlast); end
      end
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(0, 2) != 0) begin
          in_valid[i] = 1'b1;
          in_data[i*W +: W] = 8'($urandom);
          in_last[i] = ($urandom_range(0, 2) == 0);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      room = !mov || out_ready;
      hit = 0; cand = 0;
      if (owner >= 0) begin
        cand = owner; hit = 1;
      end else begin
        for (int j = N - 1; j >= 0; j--)
          if (in_valid[(mptr + j) % N]) begin cand = (mptr + j) % N; hit = 1; end
      end
      exp_rdy = (hit != 0 && room) ? N'(1 << cand) : '0;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready_%0d: got %b expected %b", k, in_ready, exp_rdy); end
      xfer = (exp_rdy != 0) && in_valid[cand];
      if (xfer) begin
        mov = 1; mdata = in_data[cand*W +: W]; mlast = in_last[cand]; msrc = cand;
        if (in_last[cand]) begin owner = -1; mptr = (cand + 1) % N; end
        else owner = cand;
      end else if (out_ready && mov) begin
        mov = 0;
      end
      @(negedge clk);
      if (xfer) in_valid[cand] = 1'b0;
    end
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_burst_lock();
    test_backpressure();
    test_reset_mid_burst();
    test_wrap3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_burst_arbiter.md
# mux_burst_arbiter

Round-robin arbiter that shares one W-bit mux datapath among N_REQ requesters. Per-requester valid/ready/last sources feed a single registered output with valid/ready. Once a requester is granted, it keeps the grant until its `last` beat has transferred. The block sits in front of any shared sink and drives the mux select from its own grant state.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16, not required to be a power of two.
- `W`, default 8: data width.
- `SRC_W`, default $clog2(N_REQ): width of the source index (localparam).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in N_REQ: per-requester beat valid.
- `in_last` in N_REQ: marks the final beat of a burst; sampled only with a transferred beat.
- `in_data` in N_REQ*W: packed; requester i occupies bits [i*W +: W].
- `in_ready` out N_REQ: per-requester accept; at most one bit set in any cycle.
- `out_valid` out 1: output register holds a beat.
- `out_data` out W: registered data.
- `out_last` out 1: registered copy of the beat's `in_last`.
- `out_src` out SRC_W: index of the requester that supplied the beat.
- `out_ready` in 1: downstream accept.

## Operation
- State machine with two states:
  - IDLE: no grant held.
  - LOCK: grant register `gnt` owns the datapath.
- Round-robin pointer `ptr` (SRC_W bits) gives the highest-priority index. Search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
- Output register has room when `!out_valid || out_ready`.
- Candidate selection:
  - In IDLE: candidate c = first `in_valid` requester in round-robin order from `ptr`.
  - In LOCK: c = `gnt`, regardless of other requesters.
- `in_ready[c]` = room, plus (state==LOCK or any `in_valid`). All other `in_ready` bits are 0.
- A transfer occurs when `in_valid[c] && in_ready[c]`. On a transfer, load the output register: `out_data`←data of c, `out_last`←`in_last[c]`, `out_src`←c, `out_valid`←1.
- Output drain: when `out_ready && out_valid` and no transfer occurs, `out_valid`←0 (data fields hold their value).
- Transitions:
  - IDLE, transfer with last=0: go to LOCK, `gnt`←c.
  - IDLE, transfer with last=1: stay in IDLE, `ptr`←c+1.
  - IDLE, no transfer: stay in IDLE. `ptr` is unchanged and no grant is latched, so the candidate may change next cycle.
  - LOCK, transfer with last=1: go to IDLE, `ptr`←`gnt`+1.
  - LOCK, otherwise: stay in LOCK. If `in_valid[gnt]` drops mid-burst, the result is bubbles; the grant is never released early.
- Pointer wrap: N_REQ-1 + 1 → 0. Compare against N_REQ-1; never rely on natural SRC_W overflow.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - state=IDLE, `ptr`=0, `gnt`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0.
  - `in_ready` is combinationally all 0 while `rst_n`=0.
- Latency: a beat accepted in cycle t appears on `out_*` in cycle t+1.
- Throughput: 1 beat/cycle sustained. A simultaneous drain and accept in the same cycle both occur.
- Combinational paths:
  - In IDLE, `in_ready` depends on `in_valid` and `out_ready`. In LOCK, it depends only on `out_ready`.
  - There is no combinational path from any input to `out_*`.
- Handshake rules:
  - Requesters must hold valid/data/last until ready.
  - The block holds `out_*` stable while `out_valid && !out_ready`.
- Reset mid-burst or with `out_valid`=1: the held beat is discarded. Arbitration restarts from requester 0.
- No requests: IDLE, all `in_ready`=0, `ptr` frozen.

## Structure
- Package `mux_arb_pkg`:
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_LOCK} arb_state_t`.
  - Maximum-N_REQ constant (16).
  - Function `rr_next(idx, n)` implementing the wrap rule.
- Sub-module `rr_priority_picker` (purely combinational):
  - Inputs: `req[N_REQ]`, `ptr`.
  - Outputs: `any`, `idx`.
  - Used only in IDLE.
- The top holds the FSM, `ptr`, `gnt`, the output register and the W-bit N:1 data mux.

## Test plan
- Reset with `in_valid`=4'b1111 held: `in_ready`=0 throughout. First edge after release: requester 0 granted. Next cycle: `out_src`=0, `out_data`=its data.
- Single-beat fairness: all four requesters valid with last=1 every beat, `out_ready`=1. `out_src` sequence must be 0,1,2,3,0,1.
- Burst lock: requester 2 sends a 3-beat burst (last on beat 3) while requester 1 is constantly valid. `out_src`=2,2,2 and only then 1. `ptr` becomes 3 after the burst.
- Backpressure: `out_ready`=0 for 5 cycles with requester 1 valid. One beat is captured; `in_ready`=0 for the remaining cycles; `out_*` stays stable. On release, back-to-back beats at 1/cycle with no loss or duplication.
- Wrap-around with N_REQ=3: `ptr`=2, requesters 0 and 2 valid → 2 granted, then `ptr`=0 → 0 granted.
- Reset mid-burst: requester 3 at beat 2 of 4, `rst_n` pulsed low asynchronously between edges. `out_valid` goes 0 immediately, state is IDLE, and requester 0 wins next.
